// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch squash and
// data-memory wait handling with a timeout watchdog that parks the core in ERR.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_valid,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] CNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StErr  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_q;

    logic load_use;
    logic mem_stall;
    logic in_err;

    // Ungated decode; the reset gate is applied at the output ports.
    logic pc_en_raw, if_id_en_raw, if_id_flush_raw, id_ex_en_raw;
    logic id_ex_flush_raw, ex_mem_en_raw, mem_wb_valid_raw;

    assign in_err   = (state_q == StErr);
    assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign mem_stall = mem_req & ~mem_ready & ((state_q == StIdle) | (state_q == StWait));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (mem_stall) begin
                    cnt_d   = WCNT_W'(1);
                    state_d = (MEM_TIMEOUT == 1) ? StErr : StWait;
                end
            end
            StWait: begin
                if (!mem_req || mem_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // This edge closes the MEM_TIMEOUT-th consecutive not-ready cycle.
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + WCNT_W'(1);
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc_en_raw        = 1'b1;
        if_id_en_raw     = 1'b1;
        if_id_flush_raw  = 1'b0;
        id_ex_en_raw     = 1'b1;
        id_ex_flush_raw  = 1'b0;
        ex_mem_en_raw    = 1'b1;
        mem_wb_valid_raw = 1'b1;
        if (in_err) begin
            pc_en_raw        = 1'b0;
            if_id_en_raw     = 1'b0;
            id_ex_en_raw     = 1'b0;
            ex_mem_en_raw    = 1'b0;
            mem_wb_valid_raw = 1'b0;
        end else if (mem_stall) begin
            // Upstream is frozen, so branch/load-use are re-evaluated once memory completes.
            pc_en_raw        = 1'b0;
            if_id_en_raw     = 1'b0;
            id_ex_en_raw     = 1'b0;
            ex_mem_en_raw    = 1'b0;
            mem_wb_valid_raw = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush_raw = 1'b1;
            id_ex_flush_raw = 1'b1;
        end else if (load_use) begin
            pc_en_raw       = 1'b0;
            if_id_en_raw    = 1'b0;
            id_ex_flush_raw = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_en_raw && !in_err && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign pc_en        = ~reset & pc_en_raw;
    assign if_id_en     = ~reset & if_id_en_raw;
    assign if_id_flush  = ~reset & if_id_flush_raw;
    assign id_ex_en     = ~reset & id_ex_en_raw;
    assign id_ex_flush  = ~reset & id_ex_flush_raw;
    assign ex_mem_en    = ~reset & ex_mem_en_raw;
    assign mem_wb_valid = ~reset & mem_wb_valid_raw;
    assign mem_err      = ~reset & in_err;
    assign stall_cycles = stall_q;

endmodule
